// File: rtl/siso_word_receiver.sv
// rtl/siso_word_receiver.sv - serial-to-parallel word receiver with one-entry valid/ready holding register
`timescale 1ns/1ps
module siso_word_receiver #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       d_in,
    input  logic                       d_valid,
    input  logic                       sync,
    input  logic                       par_ready,
    input  logic                       clear_ovr,
    output logic [WIDTH-1:0]           par_out,
    output logic                       par_valid,
    output logic                       overrun,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_bit;
    logic [CW-1:0]    cnt_nxt;
    logic             last;
    logic             complete;
    logic             accept;
    logic             drop;

    always_comb begin
        shifted   = MSB_FIRST ? {sr[WIDTH-2:0], d_in} : {d_in, sr[WIDTH-1:1]};
        first_bit = MSB_FIRST ? {{(WIDTH-1){1'b0}}, d_in} : {d_in, {(WIDTH-1){1'b0}}};
        last      = (bit_cnt == CW'(WIDTH - 1));
        // sync overrides completion: a realigned bit always starts a new word
        complete  = d_valid && !sync && last;
        accept    = !par_valid || par_ready;
        drop      = complete && !accept;
        sr_nxt    = sr;
        cnt_nxt   = bit_cnt;
        if (sync) begin
            sr_nxt  = d_valid ? first_bit : '0;
            cnt_nxt = d_valid ? CW'(1) : '0;
        end else if (d_valid) begin
            sr_nxt  = shifted;
            cnt_nxt = last ? '0 : bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr        <= '0;
            bit_cnt   <= '0;
            par_out   <= '0;
            par_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sr      <= sr_nxt;
            bit_cnt <= cnt_nxt;
            if (complete && accept) begin
                par_out   <= shifted;
                par_valid <= 1'b1;
            end else if (par_valid && par_ready) begin
                par_valid <= 1'b0;
            end
            // a drop on the same edge as clear_ovr keeps the flag set
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_ovr) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_siso_word_receiver.sv
// tb/tb_siso_word_receiver.sv - randomized self-checking bench for siso_word_receiver (MSB- and LSB-first)
`timescale 1ns/1ps
module tb_siso_word_receiver;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic d_in = 1'b0, d_valid = 1'b0, sync = 1'b0, par_ready = 1'b0, clear_ovr = 1'b0;
    logic [W-1:0] out_m, out_l;
    logic valid_m, valid_l, ovr_m, ovr_l;
    logic [3:0] cnt_m, cnt_l;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b1;
    bit rdy = 1'b1;

    always #5 clk = ~clk;

    siso_word_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid), .sync(sync),
        .par_ready(par_ready), .clear_ovr(clear_ovr),
        .par_out(out_m), .par_valid(valid_m), .overrun(ovr_m), .bit_cnt(cnt_m));

    siso_word_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid), .sync(sync),
        .par_ready(par_ready), .clear_ovr(clear_ovr),
        .par_out(out_l), .par_valid(valid_l), .overrun(ovr_l), .bit_cnt(cnt_l));

    // Reference: list of bits received toward the current word plus a one-entry holding slot
    int bits_q[$];
    logic [W-1:0] m_out_m = '0, m_out_l = '0;
    bit m_valid = 1'b0, m_ovr = 1'b0;
    bit m_done, m_drop;
    logic [W-1:0] wm, wl;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bits_q.delete();
            m_out_m = '0;
            m_out_l = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            m_done = 1'b0;
            m_drop = 1'b0;
            if (d_valid) begin
                if (sync) bits_q.delete();
                bits_q.push_back(int'(d_in));
            end else if (sync) begin
                bits_q.delete();
            end
            if (bits_q.size() == W) begin
                wm = '0;
                wl = '0;
                for (int i = 0; i < W; i++) begin
                    wm = wm | (W'(bits_q[i]) << (W - 1 - i));
                    wl = wl | (W'(bits_q[i]) << i);
                end
                bits_q.delete();
                m_done = 1'b1;
            end
            if (m_done) begin
                if (!m_valid || par_ready) begin
                    m_out_m = wm;
                    m_out_l = wl;
                    m_valid = 1'b1;
                end else begin
                    m_drop = 1'b1;
                end
            end else if (m_valid && par_ready) begin
                m_valid = 1'b0;
            end
            if (m_drop) m_ovr = 1'b1;
            else if (clear_ovr) m_ovr = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_m",   32'(out_m),   32'(m_out_m));
            check("valid_m", 32'(valid_m), 32'(m_valid));
            check("ovr_m",   32'(ovr_m),   32'(m_ovr));
            check("cnt_m",   32'(cnt_m),   32'(bits_q.size()));
            check("out_l",   32'(out_l),   32'(m_out_l));
            check("valid_l", 32'(valid_l), 32'(m_valid));
            check("ovr_l",   32'(ovr_l),   32'(m_ovr));
            check("cnt_l",   32'(cnt_l),   32'(bits_q.size()));
        end
    end

    task automatic cycle(input bit dv, input bit di, input bit sy, input bit clr);
        d_valid   = dv;
        d_in      = di;
        sync      = sy;
        par_ready = rdy;
        clear_ovr = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit gaps, input bit clr_last);
        for (int i = 0; i < W; i++) begin
            if (gaps && (i % 3 == 1)) cycle(1'b0, 1'b1, 1'b0, 1'b0);
            cycle(1'b1, w[W-1-i], 1'b0, clr_last && (i == W - 1));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out", 32'(out_m), 32'h0);
        check("rst_valid", 32'(valid_m), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            check("idle_out", 32'(out_m), 32'h0);
            check("idle_cnt", 32'(cnt_m), 32'h0);
        end

        rdy = 1'b1;
        send_word(8'h1E, 1'b0, 1'b0);
        check("msb_word", 32'(out_m), 32'h1E);
        check("lsb_word", 32'(out_l), 32'h78);
        check("word_valid", 32'(valid_m), 32'h1);
        check("model_pin_m", 32'(m_out_m), 32'h1E);
        check("model_pin_l", 32'(m_out_l), 32'h78);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("valid_one_cycle", 32'(valid_m), 32'h0);

        send_word(8'hA5, 1'b1, 1'b0);
        check("gap_word", 32'(out_m), 32'hA5);
        check("gap_cnt_wrap", 32'(cnt_m), 32'h0);
        send_word(8'h3C, 1'b0, 1'b0);
        check("b2b_word", 32'(out_m), 32'h3C);
        check("b2b_valid", 32'(valid_m), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        rdy = 1'b0;
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        check("stall_hold", 32'(out_m), 32'h11);
        check("stall_ovr", 32'(ovr_m), 32'h1);
        rdy = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_valid", 32'(valid_m), 32'h0);
        check("clr_ovr", 32'(ovr_m), 32'h0);

        rdy = 1'b0;
        send_word(8'h55, 1'b0, 1'b0);
        send_word(8'h66, 1'b0, 1'b1);
        check("set_beats_clr", 32'(ovr_m), 32'h1);
        rdy = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_cleared", 32'(ovr_m), 32'h0);

        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("sync_cnt", 32'(cnt_m), 32'h1);
        for (int i = 0; i < 7; i++) cycle(1'b1, i == 6, 1'b0, 1'b0);
        check("sync_word", 32'(out_m), 32'h81);
        check("sync_word_l", 32'(out_l), 32'h81);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("sync_no_complete", 32'(valid_m), 32'h0);
        check("sync_last_cnt", 32'(cnt_m), 32'h1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("sync_idle_cnt", 32'(cnt_m), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            rdy = ((i / 200) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 31) == 0,
                  $urandom_range(0, 15) == 0);
        end

        rdy = 1'b0;
        send_word(8'hC3, 1'b0, 1'b0);
        send_word(8'h0F, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("async_out", 32'(out_m), 32'h0);
        check("async_valid", 32'(valid_m), 32'h0);
        check("async_ovr", 32'(ovr_m), 32'h0);
        check("async_cnt", 32'(cnt_l), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        rdy = 1'b1;
        send_word(8'h96, 1'b0, 1'b0);
        check("post_reset_word", 32'(out_m), 32'h96);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
